// File: rtl/fwd_pipe_unit_pkg.sv
// fwd_pkg: shared types for the post-EX forwarding / hazard unit.
//   stall_e      reason the front end is held this cycle
//   STALL_CNT_W  width of the saturating stalled-cycle counter
// The per-stage entry struct depends on DW/RW, so it is declared inside
// fwd_pipe_unit rather than here.
package fwd_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        FREEZE = 2'd2
    } stall_e;

endpackage

// File: rtl/fwd_pipe_unit_if.sv
// fwd_pipe_unit_if: EX-side, memory-side and register-file-side signals of
// the forwarding unit.
//   master : the surrounding pipeline (drives ex_*, mem_*, cnt_clr)
//   slave  : fwd_pipe_unit (drives fwd_*, hz_stall, stall_*, wb_*)
interface fwd_pipe_unit_if
    import fwd_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic                   ex_valid;
    logic [RW-1:0]          ex_rs;
    logic [RW-1:0]          ex_rt;
    logic                   ex_rs_used;
    logic                   ex_rt_used;
    logic [DW-1:0]          ex_rs_val;
    logic [DW-1:0]          ex_rt_val;
    logic                   ex_wr_en;
    logic [RW-1:0]          ex_wr_reg;
    logic                   ex_is_load;
    logic [DW-1:0]          ex_result;
    logic                   mem_done;
    logic [DW-1:0]          mem_rdata;
    logic                   cnt_clr;
    logic [DW-1:0]          fwd_rs;
    logic [DW-1:0]          fwd_rt;
    logic                   hz_stall;
    stall_e                 stall_cause;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   wb_wr_en;
    logic [RW-1:0]          wb_wr_reg;
    logic [DW-1:0]          wb_wr_data;

    modport master (
        output ex_valid, ex_rs, ex_rt, ex_rs_used, ex_rt_used, ex_rs_val,
               ex_rt_val, ex_wr_en, ex_wr_reg, ex_is_load, ex_result,
               mem_done, mem_rdata, cnt_clr,
        input  fwd_rs, fwd_rt, hz_stall, stall_cause, stall_cnt,
               wb_wr_en, wb_wr_reg, wb_wr_data
    );

    modport slave (
        input  ex_valid, ex_rs, ex_rt, ex_rs_used, ex_rt_used, ex_rs_val,
               ex_rt_val, ex_wr_en, ex_wr_reg, ex_is_load, ex_result,
               mem_done, mem_rdata, cnt_clr,
        output fwd_rs, fwd_rt, hz_stall, stall_cause, stall_cnt,
               wb_wr_en, wb_wr_reg, wb_wr_data
    );

endinterface

// File: rtl/fwd_pipe_unit_match.sv
// fwd_match: youngest-writer select for one EX source operand.
//   ent_live  per-entry vld & wr (index 0 = MEM, the youngest)
//   ent_reg   per-entry destination register
//   ent_dvld  per-entry data-valid
//   ent_data  per-entry result
//   src       operand register number
//   rf_val    register-file value used when nothing in flight matches
//   data/hit/dvld  selected value, match flag, and whether that value exists
module fwd_match #(
    parameter int DW    = 16,
    parameter int RW    = 3,
    parameter int DEPTH = 2
) (
    input  logic [DEPTH-1:0]         ent_live,
    input  logic [DEPTH-1:0][RW-1:0] ent_reg,
    input  logic [DEPTH-1:0]         ent_dvld,
    input  logic [DEPTH-1:0][DW-1:0] ent_data,
    input  logic [RW-1:0]            src,
    input  logic [DW-1:0]            rf_val,
    output logic [DW-1:0]            data,
    output logic                     hit,
    output logic                     dvld
);

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        data = rf_val;
        hit  = 1'b0;
        dvld = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_live[k] && (ent_reg[k] == src)) begin
                data = ent_data[k];
                hit  = 1'b1;
                dvld = ent_dvld[k];
            end
        end
    end

endmodule

// File: rtl/fwd_pipe_unit.sv
// fwd_pipe_unit: owns the MEM..WB destination pipeline, forwards the youngest
// in-flight result to both EX operands, detects load-use and memory-wait
// hazards, and drives the register-file write port.
//   clk, rst_n   clock and synchronous active-low reset
//   bus (slave)  EX operands/destination, load return, counter clear in;
//                forwarded operands, stall, stall cause/count, writeback out
// DEPTH must be at least 2 (entry 0 = MEM, entry DEPTH-1 = WB).
module fwd_pipe_unit
    import fwd_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREG  = 8,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fwd_pipe_unit_if.slave  bus
);

    localparam int RW = $clog2(NREG);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

    typedef struct packed {
        logic          vld;
        logic          wr;
        logic [RW-1:0] rg;
        logic          is_load;
        logic          dvld;
        logic [DW-1:0] data;
    } entry_t;

    entry_t                 ent [DEPTH];
    entry_t                 new_ent;
    stall_e                 cause_q;
    stall_e                 cause;
    logic [STALL_CNT_W-1:0] cnt_q;

    logic [DEPTH-1:0]         ent_live;
    logic [DEPTH-1:0]         ent_dvld;
    logic [DEPTH-1:0][RW-1:0] ent_reg;
    logic [DEPTH-1:0][DW-1:0] ent_data;

    logic [DW-1:0] rs_data, rt_data;
    logic          rs_hit, rt_hit, rs_dvld, rt_dvld;
    logic          freeze, lduse, stall;

    always_comb begin
        ent_live = '0;
        ent_dvld = '0;
        ent_reg  = '0;
        ent_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_live[k] = ent[k].vld & ent[k].wr;
            ent_dvld[k] = ent[k].dvld;
            ent_reg[k]  = ent[k].rg;
            ent_data[k] = ent[k].data;
        end
    end

    fwd_match #(.DW(DW), .RW(RW), .DEPTH(DEPTH)) u_match_rs (
        .ent_live (ent_live),
        .ent_reg  (ent_reg),
        .ent_dvld (ent_dvld),
        .ent_data (ent_data),
        .src      (bus.ex_rs),
        .rf_val   (bus.ex_rs_val),
        .data     (rs_data),
        .hit      (rs_hit),
        .dvld     (rs_dvld)
    );

    fwd_match #(.DW(DW), .RW(RW), .DEPTH(DEPTH)) u_match_rt (
        .ent_live (ent_live),
        .ent_reg  (ent_reg),
        .ent_dvld (ent_dvld),
        .ent_data (ent_data),
        .src      (bus.ex_rt),
        .rf_val   (bus.ex_rt_val),
        .data     (rt_data),
        .hit      (rt_hit),
        .dvld     (rt_dvld)
    );

    // A load already in MEM with mem_done still causes LDUSE: there is no
    // mem_rdata -> EX bypass, the value is picked up from entry 1 next cycle.
    assign freeze = ent[0].vld & ent[0].is_load & ~bus.mem_done;
    assign lduse  = bus.ex_valid &
                    ((bus.ex_rs_used & rs_hit & ~rs_dvld) |
                     (bus.ex_rt_used & rt_hit & ~rt_dvld));
    assign stall  = freeze | lduse;

    always_comb begin
        cause = RUN;
        if (freeze) begin
            cause = FREEZE;
        end else if (lduse) begin
            cause = LDUSE;
        end
    end

    always_comb begin
        new_ent         = '0;
        new_ent.vld     = bus.ex_valid & ~lduse;
        new_ent.wr      = bus.ex_wr_en;
        new_ent.rg      = bus.ex_wr_reg;
        new_ent.is_load = bus.ex_is_load;
        new_ent.dvld    = ~bus.ex_is_load;
        new_ent.data    = bus.ex_result;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent[k] <= '0;
            end
            cause_q <= RUN;
            cnt_q   <= '0;
        end else begin
            cause_q <= cause;
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (!freeze) begin
                ent[0] <= new_ent;
                for (int k = 1; k < DEPTH; k++) begin
                    ent[k] <= ent[k-1];
                end
                // Not frozen implies mem_done is high for a load in MEM.
                if (ent[0].vld && ent[0].is_load) begin
                    ent[1].data <= bus.mem_rdata;
                    ent[1].dvld <= 1'b1;
                end
            end
        end
    end

    assign bus.fwd_rs      = rs_data;
    assign bus.fwd_rt      = rt_data;
    assign bus.hz_stall    = stall;
    assign bus.stall_cause = cause_q;
    assign bus.stall_cnt   = cnt_q;
    assign bus.wb_wr_en    = ent[DEPTH-1].vld & ent[DEPTH-1].wr & ~freeze;
    assign bus.wb_wr_reg   = ent[DEPTH-1].rg;
    assign bus.wb_wr_data  = ent[DEPTH-1].data;

endmodule

// File: tb/tb_fwd_pipe_unit.sv
// Bench for fwd_pipe_unit: a list of in-flight instructions aged per advance
// predicts every output each cycle; directed scenarios add literal checks.
module tb_fwd_pipe_unit;
    import fwd_pkg::*;

    localparam int DW    = 16;
    localparam int NREG  = 8;
    localparam int RW    = 3;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fwd_pipe_unit_if #(.DW(DW), .RW(RW)) bus ();

    fwd_pipe_unit #(.DW(DW), .NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Every instruction that left EX, with its age in advances (1 = MEM).
    typedef struct {
        logic [RW-1:0] rg;
        logic [DW-1:0] val;
        bit            wr;
        bit            is_load;
        bit            known;
        int            age;
    } flight_t;

    flight_t fl[$];
    flight_t nx[$];
    int      exp_cnt   = 0;
    int      exp_cause = 0;

    function automatic void lookup(input logic [RW-1:0] r, input logic [DW-1:0] dflt,
                                   output logic [DW-1:0] v, output bit hit, output bit known);
        int best;
        best  = 1000;
        v     = dflt;
        hit   = 0;
        known = 1;
        foreach (fl[i]) begin
            if (fl[i].wr && fl[i].rg == r && fl[i].age < best) begin
                best  = fl[i].age;
                v     = fl[i].val;
                hit   = 1;
                known = fl[i].known;
            end
        end
    endfunction

    function automatic bit m_freeze();
        foreach (fl[i]) begin
            if (fl[i].age == 1 && fl[i].is_load && !bus.mem_done) return 1;
        end
        return 0;
    endfunction

    function automatic bit m_lduse();
        logic [DW-1:0] v;
        bit h_s, k_s, h_t, k_t;
        lookup(bus.ex_rs, bus.ex_rs_val, v, h_s, k_s);
        lookup(bus.ex_rt, bus.ex_rt_val, v, h_t, k_t);
        return bus.ex_valid && ((bus.ex_rs_used && h_s && !k_s) ||
                                (bus.ex_rt_used && h_t && !k_t));
    endfunction

    always @(posedge clk) begin
        bit fz, lu;
        flight_t e;
        if (!rst_n) begin
            fl.delete();
            exp_cnt   = 0;
            exp_cause = 0;
        end else begin
            fz = m_freeze();
            lu = m_lduse();
            exp_cause = fz ? 2 : (lu ? 1 : 0);
            if (bus.cnt_clr) exp_cnt = 0;
            else if ((fz || lu) && exp_cnt < 65535) exp_cnt++;
            if (!fz) begin
                nx.delete();
                foreach (fl[i]) begin
                    e = fl[i];
                    if (e.age == 1 && e.is_load) begin
                        e.val   = bus.mem_rdata;
                        e.known = 1;
                    end
                    e.age++;
                    if (e.age <= DEPTH) nx.push_back(e);
                end
                if (bus.ex_valid && !lu) begin
                    e.rg      = bus.ex_wr_reg;
                    e.val     = bus.ex_result;
                    e.wr      = bus.ex_wr_en;
                    e.is_load = bus.ex_is_load;
                    e.known   = !bus.ex_is_load;
                    e.age     = 1;
                    nx.push_back(e);
                end
                fl = nx;
            end
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] vs, vt;
        bit h, k, fz, lu, wb;
        logic [RW-1:0] wreg;
        logic [DW-1:0] wdat;
        if (rst_n === 1'b1) begin
            lookup(bus.ex_rs, bus.ex_rs_val, vs, h, k);
            lookup(bus.ex_rt, bus.ex_rt_val, vt, h, k);
            fz = m_freeze();
            lu = m_lduse();
            wb = 0;
            wreg = '0;
            wdat = '0;
            foreach (fl[i]) begin
                if (fl[i].age == DEPTH && fl[i].wr && !fz) begin
                    wb   = 1;
                    wreg = fl[i].rg;
                    wdat = fl[i].val;
                end
            end
            chk("m_fwd_rs", bus.fwd_rs, vs);
            chk("m_fwd_rt", bus.fwd_rt, vt);
            chk("m_hz_stall", bus.hz_stall, fz || lu);
            chk("m_stall_cause", bus.stall_cause, exp_cause);
            chk("m_stall_cnt", bus.stall_cnt, exp_cnt);
            chk("m_wb_wr_en", bus.wb_wr_en, wb);
            if (wb) begin
                chk("m_wb_wr_reg", bus.wb_wr_reg, wreg);
                chk("m_wb_wr_data", bus.wb_wr_data, wdat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid   = 0;
        bus.ex_rs      = '0;
        bus.ex_rt      = '0;
        bus.ex_rs_used = 0;
        bus.ex_rt_used = 0;
        bus.ex_rs_val  = 16'hA5A5;
        bus.ex_rt_val  = 16'h5A5A;
        bus.ex_wr_en   = 0;
        bus.ex_wr_reg  = '0;
        bus.ex_is_load = 0;
        bus.ex_result  = '0;
        bus.mem_done   = 0;
        bus.mem_rdata  = '0;
        bus.cnt_clr    = 0;
    endtask

    task automatic writer(input logic [RW-1:0] r, input logic [DW-1:0] res, input bit ld);
        idle();
        bus.ex_valid   = 1;
        bus.ex_wr_en   = 1;
        bus.ex_wr_reg  = r;
        bus.ex_is_load = ld;
        bus.ex_result  = res;
    endtask

    task automatic consumer(input logic [RW-1:0] rs, input bit rs_u,
                            input logic [RW-1:0] rt, input bit rt_u);
        idle();
        bus.ex_valid   = 1;
        bus.ex_rs      = rs;
        bus.ex_rs_used = rs_u;
        bus.ex_rt      = rt;
        bus.ex_rt_used = rt_u;
    endtask

    initial begin
        rst_n = 0;
        idle();
        step();
        step();
        rst_n = 1;
        @(negedge clk);
        chk("rst_hz_stall", bus.hz_stall, 0);
        chk("rst_wb_wr_en", bus.wb_wr_en, 0);
        chk("rst_fwd_rs", bus.fwd_rs, 16'hA5A5);
        chk("rst_fwd_rt", bus.fwd_rt, 16'h5A5A);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_stall_cause", bus.stall_cause, 0);

        // ALU chain
        step(); writer(3'd1, 16'd5, 0);
        step(); consumer(3'd1, 1, 3'd0, 0);
        @(negedge clk);
        chk("alu_fwd_rs", bus.fwd_rs, 16'd5);
        chk("alu_hz_stall", bus.hz_stall, 0);
        step(); idle(); bus.ex_rs = 3'd1;
        @(negedge clk);
        chk("alu_wb_en", bus.wb_wr_en, 1);
        chk("alu_wb_reg", bus.wb_wr_reg, 1);
        chk("alu_wb_data", bus.wb_wr_data, 16'd5);
        step(); idle(); bus.ex_rs = 3'd1;
        step(); idle(); bus.ex_rs = 3'd1;
        @(negedge clk);
        chk("alu_gone_fwd_rs", bus.fwd_rs, 16'hA5A5);

        // youngest wins
        step(); writer(3'd2, 16'h1111, 0);
        step(); writer(3'd2, 16'h2222, 0);
        step(); consumer(3'd0, 0, 3'd2, 1);
        @(negedge clk);
        chk("young_fwd_rt", bus.fwd_rt, 16'h2222);

        // load-use
        step(); idle();
        step(); writer(3'd3, 16'hDEAD, 1);
        step(); consumer(3'd3, 1, 3'd0, 0); bus.mem_done = 1; bus.mem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("ld_hz_stall", bus.hz_stall, 1);
        step(); consumer(3'd3, 1, 3'd0, 0);
        @(negedge clk);
        chk("ld_hz_release", bus.hz_stall, 0);
        chk("ld_fwd_rs", bus.fwd_rs, 16'hBEEF);
        chk("ld_cause", bus.stall_cause, 1);
        chk("ld_cnt", bus.stall_cnt, 1);
        chk("ld_wb_en", bus.wb_wr_en, 1);
        chk("ld_wb_reg", bus.wb_wr_reg, 3);
        chk("ld_wb_data", bus.wb_wr_data, 16'hBEEF);
        step(); idle();
        @(negedge clk);
        chk("ld_cause_run", bus.stall_cause, 0);

        // memory wait
        step(); idle(); bus.cnt_clr = 1;
        step(); writer(3'd5, 16'h0055, 0);
        @(negedge clk);
        chk("mw_cnt_cleared", bus.stall_cnt, 0);
        step(); writer(3'd4, 16'h0BAD, 1);
        for (int i = 0; i < 3; i++) begin
            step(); idle(); bus.ex_rs = 3'd4;
            @(negedge clk);
            chk("mw_hz_stall", bus.hz_stall, 1);
            chk("mw_wb_en_frozen", bus.wb_wr_en, 0);
            chk("mw_cause_now", bus.stall_cause, (i == 0) ? 0 : 2);
        end
        step(); idle(); bus.mem_done = 1; bus.mem_rdata = 16'h4444;
        @(negedge clk);
        chk("mw_hz_release", bus.hz_stall, 0);
        chk("mw_cnt", bus.stall_cnt, 3);
        chk("mw_wb5_en", bus.wb_wr_en, 1);
        chk("mw_wb5_data", bus.wb_wr_data, 16'h0055);
        step(); idle();
        @(negedge clk);
        chk("mw_wb4_reg", bus.wb_wr_reg, 4);
        chk("mw_wb4_data", bus.wb_wr_data, 16'h4444);

        // unused operand against a stage-1 load
        step(); idle();
        step(); writer(3'd6, 16'h6666, 1);
        step(); consumer(3'd0, 0, 3'd6, 0); bus.mem_done = 1; bus.mem_rdata = 16'h0666;
        @(negedge clk);
        chk("unused_hz_stall", bus.hz_stall, 0);
        step(); idle();

        // reset while frozen
        step(); writer(3'd7, 16'h7777, 1);
        step(); idle();
        @(negedge clk);
        chk("rf_hz_stall", bus.hz_stall, 1);
        step(); idle(); rst_n = 0;
        step(); idle(); rst_n = 1;
        @(negedge clk);
        chk("rf_hz_stall_after", bus.hz_stall, 0);
        chk("rf_wb_en", bus.wb_wr_en, 0);
        chk("rf_cnt", bus.stall_cnt, 0);
        chk("rf_cause", bus.stall_cause, 0);
        chk("rf_fwd_rs", bus.fwd_rs, 16'hA5A5);
        step(); idle(); bus.mem_done = 1;
        @(negedge clk);
        chk("rf_no_wb", bus.wb_wr_en, 0);

        // counter saturation and clear-over-increment
        step(); writer(3'd1, 16'h1234, 1);
        step(); idle();
        repeat (65540) step();
        @(negedge clk);
        chk("sat_cnt", bus.stall_cnt, 16'hFFFF);
        chk("sat_hz_stall", bus.hz_stall, 1);
        step(); idle(); bus.cnt_clr = 1;
        step(); idle();
        @(negedge clk);
        chk("clr_cnt", bus.stall_cnt, 0);
        chk("clr_hz_stall", bus.hz_stall, 1);
        step(); idle(); bus.mem_done = 1; bus.mem_rdata = 16'h9999;
        step(); idle();
        @(negedge clk);
        chk("sat_wb_data", bus.wb_wr_data, 16'h9999);
        step(); idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_pipe_unit.md
# fwd_pipe_unit

Parametrised forwarding and hazard unit owning the post-EX destination pipeline (MEM through WB). It tracks `DEPTH` in-flight writer entries (tag plus data), selects the youngest matching result for both EX operands, and detects load-use hazards and memory waits. It drives the `hz_stall` freeze signal and the register-file write port. It sits between the ID/EX register, the ALU operand inputs, the data memory and the register file.

## Interface
- `DW`, 16, datapath width
- `NREG`, 8, architectural register count; `RW = $clog2(NREG)` is derived
- `DEPTH`, 2, post-EX stages; entry 1 = MEM, entry `DEPTH` = WB; must be ≥ 2
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous reset, active-low; the only clock is `clk`
- `ex_valid`  in  1  valid instruction in EX
- `ex_rs`, `ex_rt`  in  RW  source register numbers
- `ex_rs_used`, `ex_rt_used`  in  1  operand actually read
- `ex_rs_val`, `ex_rt_val`  in  DW  register-file values latched in ID/EX
- `ex_wr_en`  in  1  EX instruction writes a register
- `ex_wr_reg`  in  RW  its destination register
- `ex_is_load`  in  1  EX instruction is a load
- `ex_result`  in  DW  ALU result; only ever captured into flops
- `mem_done`  in  1  load data valid this cycle
- `mem_rdata`  in  DW  load data
- `cnt_clr`  in  1  clears `stall_cnt`
- `fwd_rs`, `fwd_rt`  out  DW  forwarded operands
- `hz_stall`  out  1  hold PC/IF/ID/EX
- `stall_cause`  out  2  registered: 0 RUN, 1 LDUSE, 2 FREEZE
- `stall_cnt`  out  16  saturating count of stalled cycles
- `wb_wr_en`  out  1  register-file write enable
- `wb_wr_reg`  out  RW  register-file write register
- `wb_wr_data`  out  DW  register-file write data

## Operation
- Each entry holds: `vld`, `wr`, `reg`, `is_load`, `dvld`, `data`.
- A match for operand X is the youngest (lowest k) entry with `vld & wr & reg==ex_X`. `fwd_X` is that entry's `data`, or `ex_X_val` if there is no match.
- LDUSE: `ex_valid` and a used operand's youngest match has `dvld=0`. Only a stage-1 load can have `dvld=0`.
  - There is no same-cycle `mem_rdata`→EX forward; a load in stage 1 with `mem_done=1` still causes LDUSE.
- FREEZE: entry 1 is a valid load and `mem_done=0`. FREEZE has priority over LDUSE.
- `hz_stall = FREEZE | LDUSE`.
- RUN or LDUSE, pipeline advances:
  - entry[k+1] ← entry[k].
  - entry[1] ← the EX instruction with `dvld = !ex_is_load` and `data = ex_result`. It is a bubble (`vld=0`) if LDUSE or `!ex_valid`.
  - If entry 1 is a load with `mem_done`, then entry[2] gets `data = mem_rdata` and `dvld = 1`.
- FREEZE: all entries hold.
- Write port: `wb_wr_en = vld & wr` of entry `DEPTH`, with `data` and `reg` from that entry. `wb_wr_en` is forced to 0 during FREEZE.
- The register file must write through to the same-cycle ID read; that is a system requirement, not this block's.
- `stall_cause` ← current cause each cycle.
- `stall_cnt`:
  - +1 per `hz_stall` cycle, saturating at 0xFFFF.
  - `cnt_clr` wins over an increment the same cycle; the result is 0.
- Register 0 is an ordinary register, not hardwired to zero.

## Timing
- Reset (`rst_n=0` at an edge):
  - all `vld=0`, `stall_cause=0`, `stall_cnt=0`.
  - Resulting outputs: `hz_stall=0`, `wb_wr_en=0`, `fwd_X = ex_X_val`.
- Reset mid-stall drops all in-flight entries. No writeback occurs from them.
- Forwarding and stall outputs are combinational from entries plus EX inputs.
- ALU result to consumer: the next instruction forwards from entry 1 with 0 bubbles.
- Load to consumer:
  - exactly 1 LDUSE cycle if `mem_done` arrives on time.
  - plus one FREEZE cycle per cycle of `mem_done=0`.
- Writeback occurs `DEPTH` cycles after leaving EX, plus any FREEZE cycles.

## Structure
- Package `fwd_pkg`: entry struct (parametrised by DW/RW via typedef in the module), `stall_e` enum {RUN, LDUSE, FREEZE}, `STALL_CNT_W = 16`.
- Sub-module `fwd_match`: youngest-match priority select over `DEPTH` entries. It returns data, hit, and `dvld`, and is instantiated twice (rs, rt).

## Test plan
- ALU chain: `ADD r1←5`, then consumer reads r1 next cycle → `fwd_rs=5`, `hz_stall=0`. Three cycles later, r1 is no longer in any entry → `fwd_rs=ex_rs_val`.
- Youngest wins: r2←0x1111 in entry 2 and r2←0x2222 in entry 1 → `fwd_rt=0x2222`.
- Load-use: LD r3 with `mem_done=1`, `mem_rdata=0xBEEF`, and a consumer of r3 behind it:
  - `hz_stall=1` for exactly 1 cycle, `stall_cause=1` the next cycle.
  - Then `fwd_rs=0xBEEF`.
  - `stall_cnt` 0→1.
- Memory wait: LD in stage 1 with `mem_done=0` for 3 cycles:
  - `hz_stall=1` for 3 cycles, entries frozen, `wb_wr_en=0` during the freeze.
  - Then normal advance; `stall_cnt=3`.
- Unused operand: `ex_rt_used=0` matching a stage-1 load → no stall.
- Reset and counter:
  - `rst_n=0` for one cycle while FREEZE → all outputs at reset values the next cycle.
  - `stall_cnt` preset to 0xFFFF plus a stall → stays 0xFFFF.
  - `cnt_clr` together with a stall → 0.
